// File: rtl/cpu_param.sv
// cpu_param: multicycle lab-ISA core, DATA_W-bit datapath, one 16-bit instruction per start request.
// Defining CPU_INSTR_COUNT_EN adds the instr_count output (completed known instructions).
module cpu_param #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              w
`ifdef CPU_INSTR_COUNT_EN
    ,
    output logic [15:0]       instr_count
`endif
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WR_REG,
        S_WR_IMM
    } state_e;

    state_e state_q, state_d;

    logic [15:0]              ir_q;
    logic signed [DATA_W-1:0] rf_q [8];
    logic signed [DATA_W-1:0] a_q, b_q, c_q;
    logic                     n_q, v_q, z_q;

    logic [2:0] cls, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp;

    logic ld_ir, ld_a, ld_b, ld_c, wr_reg, wr_imm;

    logic signed [DATA_W-1:0] b_sh, alu_r, imm_ext;
    logic signed [7:0]        imm8;
    logic                     alu_v;

    function automatic logic signed [DATA_W-1:0] shift_op(
        input logic signed [DATA_W-1:0] x,
        input logic [1:0]               code
    );
        case (code)
            2'b01:   return x <<< 1;
            2'b10:   return x >> 1;
            2'b11:   return x >>> 1;
            default: return x;
        endcase
    endfunction

    // Subtraction overflows when operand signs differ and the result sign leaves the minuend's.
    function automatic logic sub_ovf(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] r
    );
        return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

    assign cls = ir_q[15:13];
    assign op  = ir_q[12:11];
    assign rn  = ir_q[10:8];
    assign rd  = ir_q[7:5];
    assign sh  = ir_q[4:3];
    assign rm  = ir_q[2:0];

    assign is_mov_imm = (cls == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (cls == 3'b110) && (op == 2'b00);
    assign is_alu     = (cls == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);

    assign imm8    = ir_q[7:0];
    assign imm_ext = DATA_W'(imm8);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)      state_d = S_WR_IMM;
                else if (is_mov_reg) state_d = S_GET_B;
                else if (is_alu)     state_d = S_GET_A;
                else                 state_d = S_WAIT;
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_ALU;
            S_ALU:    state_d = is_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    // IR only accepts load while idle, so the executing word cannot change under the datapath.
    always_comb begin
        w      = 1'b0;
        ld_ir  = 1'b0;
        ld_a   = 1'b0;
        ld_b   = 1'b0;
        ld_c   = 1'b0;
        wr_reg = 1'b0;
        wr_imm = 1'b0;
        case (state_q)
            S_WAIT: begin
                w     = 1'b1;
                ld_ir = load;
            end
            S_GET_A:  ld_a   = 1'b1;
            S_GET_B:  ld_b   = 1'b1;
            S_ALU:    ld_c   = 1'b1;
            S_WR_REG: wr_reg = 1'b1;
            S_WR_IMM: wr_imm = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        b_sh  = shift_op(b_q, sh);
        alu_r = b_sh;
        if (is_alu) begin
            case (op)
                2'b00:   alu_r = a_q + b_sh;
                2'b01:   alu_r = a_q - b_sh;
                2'b10:   alu_r = a_q & b_sh;
                default: alu_r = ~b_sh;
            endcase
        end
        alu_v = sub_ovf(a_q, b_sh, a_q - b_sh);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            n_q  <= 1'b0;
            v_q  <= 1'b0;
            z_q  <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            if (ld_ir) ir_q <= in;
            if (ld_a)  a_q  <= rf_q[rn];
            if (ld_b)  b_q  <= rf_q[rm];
            if (ld_c)  c_q  <= alu_r;
            if (ld_c && is_cmp) begin
                n_q <= alu_r[DATA_W-1];
                z_q <= (alu_r == '0);
                v_q <= alu_v;
            end
            if (wr_reg) rf_q[rd] <= c_q;
            if (wr_imm) rf_q[rn] <= imm_ext;
        end
    end

    assign out = c_q;
    assign N   = n_q;
    assign V   = v_q;
    assign Z   = z_q;

`ifdef CPU_INSTR_COUNT_EN
    logic        done;
    logic [15:0] cnt_q;

    // A known instruction completes on its last busy state; unknown opcodes leave from DECODE.
    assign done = (state_q == S_WR_REG) || (state_q == S_WR_IMM) ||
                  ((state_q == S_ALU) && is_cmp);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (done) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign instr_count = cnt_q;
`endif

endmodule

// File: doc/cpu_param.md
Name: cpu_param

Overview:
- Parametrised multicycle core for the lab ISA, executing one 16-bit instruction per start request.
- Generalises the lab datapath to DATA_W bits. Adds a load-gating rule, an unknown-opcode escape, and defined simultaneous-event behaviour.
- Sits under the lab top level. It is driven by switches/testbench through the s/load/w handshake.

Parameters:
- DATA_W, 16, register/ALU/out width; legal range 8..32.
- Instruction width is fixed at 16 and is not a parameter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- s  input  1  start execution of the instruction register (IR) contents
- load  input  1  capture in into IR
- in  input  16  instruction word
- out  output  DATA_W  datapath result register C
- N  output  1  negative status flag
- V  output  1  signed overflow status flag
- Z  output  1  zero status flag
- w  output  1  high while idle in WAIT

Behaviour:
- Reset (sampled at clk edge):
  - state=WAIT, w=1, out=0, N=V=Z=0, IR=0, R0..R7=0.
  - Reset mid-instruction aborts it; no register write occurs.
- Instruction fields:
  - op class in[15:13], op in[12:11]
  - Rn [10:8], Rd [7:5], sh [4:3], Rm [2:0], imm8 [7:0]
- Shifter, applied to R[Rm]: 00 none, 01 LSL1 (zero in), 10 LSR1 (zero in), 11 ASR1 (sign copy). All at DATA_W.
- Instructions:
  - 110/10 MOV Rn,#imm8: R[Rn]=sign-extend(imm8) to DATA_W; out unchanged.
  - 110/00 MOV Rd,Rm{,sh}: out=R[Rd]=sh(R[Rm]).
  - 101/00 ADD: out=R[Rd]=R[Rn]+sh(R[Rm]), mod 2^DATA_W.
  - 101/01 CMP: computes R[Rn]-sh(R[Rm]) into out; no register write.
  - 101/10 AND: out=R[Rd]=R[Rn]&sh(R[Rm]).
  - 101/11 MVN: out=R[Rd]=~sh(R[Rm]).
  - Any other class/op is unknown.
- Flags:
  - Updated only by CMP, at its ALU cycle.
  - N = result MSB; Z = result==0; V = signed overflow of the subtraction.
  - All other instructions hold the flags.
- FSM states: WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM.
  - WAIT: w=1. On s=1 go to DECODE (w=0 from next cycle).
  - DECODE: MOV imm -> WR_IMM; MOV reg -> GET_B; ALU class -> GET_A; unknown -> WAIT.
  - GET_A -> GET_B -> ALU.
  - ALU -> WR_REG, or -> WAIT for CMP.
  - WR_REG -> WAIT; WR_IMM -> WAIT.
- Cycles with w=0:
  - MOV imm: 2
  - MOV reg: 4
  - ADD/AND/MVN: 5
  - CMP: 4
  - unknown: 1
- out is loaded only in ALU state.
- Load gating:
  - load is honoured only in WAIT; ignored while busy (IR stable during execution).
  - load and s both high in WAIT: IR takes in, and execution runs the newly loaded word.
- s held high: a new instruction starts on every return to WAIT. w pulses high for exactly 1 cycle between instructions.

Optional Feature:
- Macro: CPU_INSTR_COUNT_EN.
- Defined:
  - Adds output instr_count[15:0], reset to 0.
  - Increments by 1 on each transition into WAIT from a known instruction; wraps 0xFFFF->0.
  - Unknown opcodes and reset-aborted instructions do not count.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- DATA_W=16, load 0xD007 then s; load 0xD102 then s -> w low 2 cycles each; R0=0x0007, R1=0x0002.
- Then ADD R2,R1,R0 LSL1 (0xA148) -> after 5 busy cycles out=0x0010, R2=0x0010, flags unchanged (0,0,0).
- DATA_W=16, MOV R3,#-128 (0xD380) -> R3=0xFF80. Repeat with DATA_W=32 -> R3=0xFFFFFF80.
- DATA_W=8: MOV R0,#-128; MOV R1,#1; CMP R0,R1 (0xA801) -> out=0x7F, N=0, Z=0, V=1, R0/R1 unchanged, 4 busy cycles.
- Unknown word 0xE000 with s -> exactly 1 busy cycle, no register/out/flag change. Pulse load=1 with 0xD0FF mid-ADD -> IR keeps the ADD.
- Reset asserted during GET_B of an ADD -> next edge: w=1, out=0, all registers 0. With CPU_INSTR_COUNT_EN, instr_count=0 and increments exactly once per completed MOV/ADD/CMP.
